// File: rtl/bdu_scheduler.sv
// Batch scheduler for a bit-serial distance array: streams coordinate bits
// MSB-first to NUM_BDU lanes, drains, then shifts batches until a run ends.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   start, num_refs      run request (IDLE only) and reference count
//   bdu_done, bdu_term   per-lane completion / early termination
//   shift_ready          downstream accepts the batch shift
//   bdu_valid, bit_idx   per-lane bit valid and current bit position
//   batch_base           reference index held by lane 0
//   shift, busy, done    batch shift request, activity, end-of-run pulse
//   error                sticky drain timeout, cleared by an accepted start
module bdu_scheduler #(
  parameter int NUM_BDU   = 8,
  parameter int B         = 16,
  parameter int REF_W     = 12,
  parameter int DRAIN_MAX = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [REF_W-1:0]       num_refs,
  input  logic [NUM_BDU-1:0]     bdu_done,
  input  logic [NUM_BDU-1:0]     bdu_term,
  input  logic                   shift_ready,
  output logic [NUM_BDU-1:0]     bdu_valid,
  output logic [$clog2(B)-1:0]   bit_idx,
  output logic [REF_W-1:0]       batch_base,
  output logic                   shift,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam int BW = $clog2(B);
  localparam int CW = $clog2(DRAIN_MAX + 1);
  localparam logic [BW-1:0] BIT_TOP  = BW'(B - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_SHIFT,
    S_FINISH
  } state_e;

  state_e            state_q, state_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [REF_W-1:0]  base_q, base_d;
  logic [REF_W-1:0]  nrefs_q, nrefs_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [NUM_BDU-1:0] lane_mask;
  logic               all_term;
  logic               all_done;
  logic               last_batch;

  // One extra bit keeps base+i from wrapping near the top of the index range.
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < NUM_BDU; i++) begin
      lane_mask[i] = ({1'b0, base_q} + (REF_W+1)'(i)) < {1'b0, nrefs_q};
    end
  end

  assign all_term   = &(bdu_term | ~lane_mask);
  assign all_done   = &(bdu_done | bdu_term | ~lane_mask);
  assign last_batch = ({1'b0, base_q} + (REF_W+1)'(NUM_BDU))
                      >= {1'b0, nrefs_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      bit_q   <= BIT_TOP;
      base_q  <= '0;
      nrefs_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      base_q  <= base_d;
      nrefs_q <= nrefs_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    base_d  = base_q;
    nrefs_d = nrefs_q;
    cnt_d   = '0;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          nrefs_d = num_refs;
          base_d  = '0;
          err_d   = 1'b0;
          bit_d   = BIT_TOP;
          state_d = (num_refs == '0) ? S_FINISH : S_STREAM;
        end
      end
      S_STREAM: begin
        if (bit_q != '0) bit_d = bit_q - 1'b1;
        // Stop early once every live lane has already terminated.
        if (all_term || bit_q == '0) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (all_done) begin
          state_d = S_SHIFT;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (shift_ready) begin
          if (last_batch) begin
            state_d = S_FINISH;
          end else begin
            base_d  = base_q + REF_W'(NUM_BDU);
            bit_d   = BIT_TOP;
            state_d = S_STREAM;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign bdu_valid  = (state_q == S_STREAM) ? lane_mask : '0;
  assign bit_idx    = bit_q;
  assign batch_base = base_q;
  assign shift      = (state_q == S_SHIFT);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FINISH);
  assign error      = err_q;

endmodule

// File: tb/tb_bdu_scheduler.sv
// Self-checking bench for bdu_scheduler: an expected per-cycle trace is
// generated per run from batch/lane rules, then replayed against the DUT.
module tb_bdu_scheduler;

  localparam int N  = 4;
  localparam int BB = 8;
  localparam int RW = 12;
  localparam int DM = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [RW-1:0] num_refs;
  logic [N-1:0]  bdu_done;
  logic [N-1:0]  bdu_term;
  logic          shift_ready;
  logic [N-1:0]  bdu_valid;
  logic [2:0]    bit_idx;
  logic [RW-1:0] batch_base;
  logic          shift, busy, done, error;

  int checks = 0;
  int errors = 0;

  bdu_scheduler #(
    .NUM_BDU(N), .B(BB), .REF_W(RW), .DRAIN_MAX(DM)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_refs(num_refs),
    .bdu_done(bdu_done), .bdu_term(bdu_term),
    .shift_ready(shift_ready), .bdu_valid(bdu_valid),
    .bit_idx(bit_idx), .batch_base(batch_base), .shift(shift),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  valid;
    int            bitv;
    bit            chk_bit;
    int            base;
    bit            shift;
    bit            done;
    bit            busy;
    bit            err;
    logic [N-1:0]  done_in;
    logic [N-1:0]  term_in;
    bit            ready;
    bit            start;
    logic [RW-1:0] nrefs;
  } cyc_t;

  cyc_t q[$];
  bit   model_err  = 1'b0;
  int   model_base = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic cyc_t mk(input int base, input bit busy_v);
    cyc_t e;
    e.valid = '0; e.bitv = 0; e.chk_bit = 1'b0; e.base = base;
    e.shift = 1'b0; e.done = 1'b0; e.busy = busy_v; e.err = model_err;
    e.done_in = '0; e.term_in = '0; e.ready = 1'b0;
    e.nrefs = RW'($urandom);
    // Spurious starts while busy must be ignored.
    e.start = busy_v ? ($urandom % 4 == 0) : 1'b0;
    return e;
  endfunction

  task automatic push_end(input int base);
    cyc_t e;
    e = mk(base, 1'b1);
    e.done = 1'b1;
    q.push_back(e);
    e = mk(base, 1'b0);
    q.push_back(e);
    model_base = base;
  endtask

  // term_at: -1 none, >=0 all lanes at that bit, -2 random per lane.
  // dly: done delay after drain entry, <0 random. never: 0 no, 1 all, 2 random.
  // bp: cycles of shift_ready=0, <0 random.
  task automatic build(input int nrefs, input int term_at, input int dly,
                       input int never, input int bp);
    cyc_t e;
    int   tb[N];
    int   dd[N];
    logic [N-1:0] mask, termv, donev;
    int   base, d, w;
    bit   tmo;
    e = mk(model_base, 1'b0);
    e.start = 1'b1;
    e.nrefs = RW'(nrefs);
    q.push_back(e);
    model_err = 1'b0;
    if (nrefs == 0) begin
      push_end(0);
      return;
    end
    base = 0;
    forever begin
      for (int l = 0; l < N; l++) begin
        mask[l] = (base + l) < nrefs;
        if (term_at == -2) tb[l] = ($urandom % 3 == 0) ? int'($urandom % BB) : -1;
        else tb[l] = term_at;
        dd[l] = (dly < 0) ? int'($urandom % 6) : dly;
        if (never == 1 || (never == 2 && $urandom % 10 == 0)) dd[l] = 1000;
      end
      termv = '0;
      for (int k = BB - 1; k >= 0; k--) begin
        for (int l = 0; l < N; l++) if (k <= tb[l]) termv[l] = 1'b1;
        e = mk(base, 1'b1);
        e.valid = mask; e.bitv = k; e.chk_bit = 1'b1; e.term_in = termv;
        q.push_back(e);
        if (&(termv | ~mask)) break;
      end
      d = 0;
      tmo = 1'b0;
      forever begin
        for (int l = 0; l < N; l++) donev[l] = d >= dd[l];
        e = mk(base, 1'b1);
        e.term_in = termv; e.done_in = donev;
        q.push_back(e);
        if (&(donev | termv | ~mask)) break;
        if (d == DM - 1) begin tmo = 1'b1; break; end
        d++;
      end
      if (tmo) begin
        model_err = 1'b1;
        push_end(base);
        return;
      end
      w = (bp < 0) ? int'($urandom % 4) : bp;
      for (int i = 0; i <= w; i++) begin
        e = mk(base, 1'b1);
        e.shift = 1'b1; e.ready = (i == w);
        q.push_back(e);
      end
      if (base + N >= nrefs) begin
        push_end(base);
        return;
      end
      base += N;
    end
  endtask

  task automatic compare(input cyc_t e);
    chk("bdu_valid", 32'(bdu_valid), 32'(e.valid));
    chk("shift", 32'(shift), 32'(e.shift));
    chk("done", 32'(done), 32'(e.done));
    chk("busy", 32'(busy), 32'(e.busy));
    chk("error", 32'(error), 32'(e.err));
    chk("batch_base", 32'(batch_base), 32'(e.base));
    if (e.chk_bit) chk("bit_idx", 32'(bit_idx), 32'(e.bitv));
  endtask

  // abort_bit >= 0 asserts rst during the first streaming cycle at that bit.
  task automatic execute(input int abort_bit);
    cyc_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(negedge clk);
      compare(e);
      start       = e.start;
      num_refs    = e.nrefs;
      bdu_done    = e.done_in;
      bdu_term    = e.term_in;
      shift_ready = e.ready;
      if (abort_bit >= 0 && e.valid != '0 && e.bitv == abort_bit) begin
        rst = 1'b1;
        q.delete();
      end
    end
  endtask

  task automatic check_reset();
    @(negedge clk);
    chk("rst_valid", 32'(bdu_valid), 32'd0);
    chk("rst_bit", 32'(bit_idx), 32'(BB - 1));
    chk("rst_base", 32'(batch_base), 32'd0);
    chk("rst_shift", 32'(shift), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    rst = 1'b0;
    start = 1'b0; bdu_done = '0; bdu_term = '0; shift_ready = 1'b0;
    model_err = 1'b0;
    model_base = 0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_refs = '0;
    bdu_done = '0; bdu_term = '0; shift_ready = 1'b0;
    repeat (2) @(posedge clk);
    check_reset();
    build(8, -1, 0, 0, 0);  execute(-1);
    build(6, -1, 0, 0, 0);  execute(-1);
    build(8, 5, 0, 0, 0);   execute(-1);
    build(4, -1, 2, 0, 3);  execute(-1);
    build(0, -1, 0, 0, 0);  execute(-1);
    build(4, -1, 0, 1, 0);  execute(-1);
    build(5, -1, 1, 0, 1);  execute(-1);
    build(8, -1, 0, 0, 0);  execute(3);
    check_reset();
    build(8, -1, 0, 0, 0);  execute(-1);
    for (int r = 0; r < 25; r++) begin
      build(int'($urandom % 14), -2, -1, 2, -1);
      execute(-1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
